// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int BYTE_W = 8;   // byte-wide arbiter data bus
  localparam int INST_W = 32;  // instruction width
  localparam int ADDR_W = 32;  // instruction address width

  localparam logic [INST_W-1:0] ZERO_WORD  = '0;
  localparam logic              RST_ENABLE = 1'b0;  // rst is active-low

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH      = 2'b01,
    VALID      = 2'b10,
    DRAIN      = 2'b11
  } fetch_state_e;

  // Place one returned byte into its little-endian lane of the instruction word.
  function automatic logic [INST_W-1:0] insert_byte(input logic [INST_W-1:0] word,
                                                    input logic [1:0]        lane,
                                                    input logic [BYTE_W-1:0] data);
    logic [INST_W-1:0] res;
    res = word;
    res[{lane, 3'b000} +: BYTE_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads
// over the arbiter port, holds the PC and applies redirects from decode.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              stall_req
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        k_q;
  logic [INST_W-1:0] buf_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [INST_W-1:0] if_inst_q;
  logic              stall_req_q;

  logic              squash;
  logic [INST_W-1:0] assembled_d;
  logic [ADDR_W-1:0] valid_pc_d;
  logic [ADDR_W-1:0] drain_tgt_d;
  logic [ADDR_W-1:0] byte_addr_d;
  logic              stall_unused;

  // Only stall[0] (hold IF) matters to this stage.
  assign stall_unused = ^stall[4:1];

  // A redirect kills whatever is presented in the very cycle it is raised.
  assign squash      = rdy & branch_flag;
  assign assembled_d = insert_byte(buf_q, k_q, mem_rdata);
  assign valid_pc_d  = branch_flag ? branch_addr : pc_q + 32'd4;
  // While draining, a newer redirect replaces the saved target.
  assign drain_tgt_d = branch_flag ? branch_addr : tgt_q;
  assign byte_addr_d = pc_q + {30'b0, k_q};

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign if_pc     = squash ? ZERO_WORD : if_pc_q;
  assign if_inst   = squash ? ZERO_WORD : if_inst_q;
  assign stall_req = squash | stall_req_q;

  // Fetch FSM with registered bus and IF/ID-side outputs; DRAIN doubles as
  // the pending-redirect flag since it is only entered with a target saved.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would leak new values into later lines.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      k_q         <= 2'd0;
      // NOTE: the assembly buffer is an ordinary register, not a RAM, so it
      // is reset like everything else and never exposes X.
      buf_q       <= ZERO_WORD;
      tgt_q       <= ZERO_WORD;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= ZERO_WORD;
      if_pc_q     <= ZERO_WORD;
      if_inst_q   <= ZERO_WORD;
      stall_req_q <= 1'b1;
    end else if (rdy) begin
      case (state_q)
        FETCH: begin
          if (!mem_req_q) begin
            // First cycle out of reset: open the first request.
            mem_req_q <= 1'b1;
            if (branch_flag) begin
              pc_q       <= branch_addr;
              mem_addr_q <= branch_addr;
            end else begin
              mem_addr_q <= byte_addr_d;
            end
          end else if (branch_flag) begin
            if (mem_ack) begin
              // Byte arrived with the redirect: drop it and restart at once.
              pc_q       <= branch_addr;
              k_q        <= 2'd0;
              mem_addr_q <= branch_addr;
            end else begin
              // Request cannot be withdrawn; wait for it in DRAIN.
              tgt_q   <= branch_addr;
              state_q <= DRAIN;
            end
          end else if (mem_ack) begin
            buf_q <= assembled_d;
            if (k_q == 2'd3) begin
              state_q     <= VALID;
              k_q         <= 2'd0;
              mem_req_q   <= 1'b0;
              if_pc_q     <= pc_q;
              if_inst_q   <= assembled_d;
              stall_req_q <= 1'b0;
            end else begin
              k_q        <= k_q + 2'd1;
              mem_addr_q <= byte_addr_d + 32'd1;
            end
          end
        end
        VALID: begin
          // A redirect wins over stall[0].
          if (branch_flag || !stall[0]) begin
            state_q     <= FETCH;
            pc_q        <= valid_pc_d;
            k_q         <= 2'd0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= valid_pc_d;
            if_pc_q     <= ZERO_WORD;
            if_inst_q   <= ZERO_WORD;
            stall_req_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state_q    <= FETCH;
            pc_q       <= drain_tgt_d;
            k_q        <= 2'd0;
            mem_addr_q <= drain_tgt_d;
          end else begin
            tgt_q <= drain_tgt_d;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule
